// File: rtl/segment_write_sequencer_if.sv
// segment_write_sequencer_if: bundle of CPU, savestate and register-file
// write-port signals around the segment write sequencer.
// master = CPU core / savestate controller / register file side,
// slave  = the sequencer itself.
interface segment_write_sequencer_if #(
    parameter int NUM_SEGS = 4,
    parameter int SEG_W    = 16
);
    localparam int IDW = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;

    logic                      cpu_req;
    logic [IDW-1:0]            cpu_id;
    logic [SEG_W-1:0]          cpu_data;
    logic                      cpu_ack;
    logic                      st_load_start;
    logic [SEG_W-1:0]          st_load_data;
    logic                      st_load_valid;
    logic                      st_load_ready;
    logic                      st_dump_start;
    logic [SEG_W-1:0]          st_dump_data;
    logic                      st_dump_valid;
    logic                      st_dump_ready;
    logic [NUM_SEGS*SEG_W-1:0] seg_q;
    logic                      rf_we;
    logic [IDW-1:0]            rf_id;
    logic [SEG_W-1:0]          rf_data;
    logic                      busy;
    logic                      done;

    modport slave (
        input  cpu_req, cpu_id, cpu_data,
        input  st_load_start, st_load_data, st_load_valid,
        input  st_dump_start, st_dump_ready, seg_q,
        output cpu_ack, st_load_ready, st_dump_data, st_dump_valid,
        output rf_we, rf_id, rf_data, busy, done
    );

    modport master (
        output cpu_req, cpu_id, cpu_data,
        output st_load_start, st_load_data, st_load_valid,
        output st_dump_start, st_dump_ready, seg_q,
        input  cpu_ack, st_load_ready, st_dump_data, st_dump_valid,
        input  rf_we, rf_id, rf_data, busy, done
    );
endinterface

// File: rtl/segment_write_sequencer.sv
// segment_write_sequencer: owns the single write port of the segment
// register file. Grants CPU writes while idle, streams a savestate load
// into registers 0..NUM_SEGS-1, and (with SEG_DUMP_EN defined) streams the
// current register contents out as a savestate dump.
// Optional feature macro: SEG_DUMP_EN.
module segment_write_sequencer #(
    parameter int NUM_SEGS = 4,
    parameter int SEG_W    = 16
) (
    input logic                      clk,
    input logic                      reset,
    segment_write_sequencer_if.slave bus
);
    localparam int IDW = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam logic [IDW-1:0] LAST = IDW'(NUM_SEGS - 1);

`ifdef SEG_DUMP_EN
    typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

    state_t           state;
    logic [IDW-1:0]   idx;
    logic             rf_we;
    logic [IDW-1:0]   rf_id;
    logic [SEG_W-1:0] rf_data;
    logic             done;
    logic             load_hs;

    // CPU is only granted while idle; load words are accepted every LOAD cycle
    assign bus.cpu_ack       = bus.cpu_req & (state == IDLE);
    assign bus.st_load_ready = (state == LOAD);
    assign load_hs           = bus.st_load_valid & (state == LOAD);
    assign bus.busy          = (state != IDLE);
    assign bus.rf_we         = rf_we;
    assign bus.rf_id         = rf_id;
    assign bus.rf_data       = rf_data;
    assign bus.done          = done;

`ifdef SEG_DUMP_EN
    logic dump_valid;
    logic dump_hs;
    // Hold off valid while a write is committing so seg_q is never stale
    assign dump_valid        = (state == DUMP) & ~rf_we;
    assign dump_hs           = dump_valid & bus.st_dump_ready;
    assign bus.st_dump_valid = dump_valid;
    assign bus.st_dump_data  = bus.seg_q[int'(idx)*SEG_W +: SEG_W];
`else
    logic unused_dump;
    assign unused_dump       = ^{bus.st_dump_start, bus.st_dump_ready, bus.seg_q};
    assign bus.st_dump_valid = 1'b0;
    assign bus.st_dump_data  = '0;
`endif

    // Sequencer FSM; write port and done are registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            rf_we   <= 1'b0;
            rf_id   <= '0;
            rf_data <= '0;
            done    <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        rf_we   <= 1'b1;
                        rf_id   <= bus.cpu_id;
                        rf_data <= bus.cpu_data;
                    end
                    // load wins over a simultaneous dump start
                    if (bus.st_load_start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
`ifdef SEG_DUMP_EN
                    else if (bus.st_dump_start) begin
                        state <= DUMP;
                        idx   <= '0;
                    end
`endif
                end
                LOAD: begin
                    if (load_hs) begin
                        rf_we   <= 1'b1;
                        rf_id   <= idx;
                        rf_data <= bus.st_load_data;
                        if (idx == LAST) begin
                            state <= IDLE;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef SEG_DUMP_EN
                DUMP: begin
                    if (dump_hs) begin
                        if (idx == LAST) begin
                            state <= IDLE;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_segment_write_sequencer.sv
// tb_segment_write_sequencer: table-driven CPU write vectors plus directed
// load / dump / reset sequences; every register-file write is checked
// against a scoreboard queue filled when the stimulus is driven.
module tb_segment_write_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    segment_write_sequencer_if #(.NUM_SEGS(4), .SEG_W(16)) sif ();

    segment_write_sequencer #(.NUM_SEGS(4), .SEG_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    typedef struct { logic req; logic [1:0] id; logic [15:0] data; logic ack; } vec_t;
    typedef struct { logic [1:0] id; logic [15:0] data; } wr_t;

    int  total = 0;
    int  bad   = 0;
    wr_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] data);
        wr_t w;
        w.id = id; w.data = data;
        sb.push_back(w);
    endtask

    // every committed write must match the oldest expected write
    always @(negedge clk) begin
        if (sif.rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got id=%0d data=%h expected no write", sif.rf_id, sif.rf_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_id", 32'(sif.rf_id), 32'(e.id));
                chk("wr_data", 32'(sif.rf_data), 32'(e.data));
            end
        end
    end

    // streams four load words with valid held high; cpu_ack must stay low
    // until the return to IDLE, where a held cpu_req is acked at once
    task automatic load_words(input logic [3:0][15:0] w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("load_done_low", 32'(sif.done), 32'd0);
            sif.st_load_valid = 1'b1;
            sif.st_load_data  = w[k];
            #1;
            chk("load_ready", 32'(sif.st_load_ready), 32'd1);
            chk("load_busy", 32'(sif.busy), 32'd1);
            chk("load_cpu_stall", 32'(sif.cpu_ack), 32'd0);
            push(2'(k), w[k]);
        end
        @(negedge clk);
        sif.st_load_valid = 1'b0;
        #1;
        chk("load_done", 32'(sif.done), 32'd1);
        chk("load_idle", 32'(sif.busy), 32'd0);
        chk("load_ready_off", 32'(sif.st_load_ready), 32'd0);
        chk("post_load_ack", 32'(sif.cpu_ack), 32'(sif.cpu_req));
        if (sif.cpu_req) push(sif.cpu_id, sif.cpu_data);
        @(negedge clk);
        sif.cpu_req = 1'b0;
        chk("done_single", 32'(sif.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic prev;
        tbl[0] = '{1'b1, 2'd2, 16'h1234, 1'b1};
        tbl[1] = '{1'b0, 2'd0, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 2'd0, 16'hAAAA, 1'b1};
        tbl[3] = '{1'b1, 2'd3, 16'hFFFF, 1'b1};
        tbl[4] = '{1'b0, 2'd1, 16'h5555, 1'b0};
        tbl[5] = '{1'b1, 2'd1, 16'h0001, 1'b1};

        reset = 1'b1;
        sif.cpu_req = 0; sif.cpu_id = 0; sif.cpu_data = 0;
        sif.st_load_start = 0; sif.st_load_data = 0; sif.st_load_valid = 0;
        sif.st_dump_start = 0; sif.st_dump_ready = 0;
        sif.seg_q = {16'h0003, 16'h0002, 16'hFFFF, 16'h0000};
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_rf_we", 32'(sif.rf_we), 32'd0);
        chk("rst_rf_id", 32'(sif.rf_id), 32'd0);
        chk("rst_rf_data", 32'(sif.rf_data), 32'd0);
        chk("rst_busy", 32'(sif.busy), 32'd0);
        chk("rst_done", 32'(sif.done), 32'd0);
        chk("rst_load_ready", 32'(sif.st_load_ready), 32'd0);
        chk("rst_dump_valid", 32'(sif.st_dump_valid), 32'd0);

        // CPU write vectors, back to back
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            chk("cpu_we_pipe", 32'(sif.rf_we), 32'(prev));
            sif.cpu_req  = tbl[i].req;
            sif.cpu_id   = tbl[i].id;
            sif.cpu_data = tbl[i].data;
            #1;
            chk("cpu_ack", 32'(sif.cpu_ack), 32'(tbl[i].ack));
            if (tbl[i].ack) push(tbl[i].id, tbl[i].data);
            prev = tbl[i].ack;
        end
        @(negedge clk);
        chk("cpu_we_last", 32'(sif.rf_we), 32'(prev));
        sif.cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_we_idle", 32'(sif.rf_we), 32'd0);

        // load with cpu_req held from the cycle after start
        sif.st_load_start = 1'b1;
        @(negedge clk);
        sif.st_load_start = 1'b0;
        sif.cpu_req = 1'b1; sif.cpu_id = 2'd3; sif.cpu_data = 16'hBEEF;
        load_words({16'h8000, 16'h0001, 16'hFFFF, 16'hAAAA});
        @(negedge clk);

        // start and CPU request in the same cycle
        sif.st_load_start = 1'b1;
        sif.cpu_req = 1'b1; sif.cpu_id = 2'd1; sif.cpu_data = 16'h00FF;
        #1;
        chk("start_cpu_ack", 32'(sif.cpu_ack), 32'd1);
        push(2'd1, 16'h00FF);
        @(negedge clk);
        sif.st_load_start = 1'b0;
        sif.cpu_req = 1'b0;
        #1;
        chk("start_cpu_load", 32'(sif.busy), 32'd1);
        load_words({16'h0013, 16'h0012, 16'h0011, 16'h0010});

        // reset after two load words
        @(negedge clk);
        sif.st_load_start = 1'b1;
        @(negedge clk);
        sif.st_load_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sif.st_load_valid = 1'b1;
            sif.st_load_data  = 16'h4400 + 16'(k);
            push(2'(k), 16'h4400 + 16'(k));
            @(negedge clk);
        end
        sif.st_load_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(sif.busy), 32'd0);
        chk("abort_done", 32'(sif.done), 32'd0);
        chk("abort_rf_we", 32'(sif.rf_we), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_done2", 32'(sif.done), 32'd0);
        sif.st_load_start = 1'b1;
        @(negedge clk);
        sif.st_load_start = 1'b0;
        load_words({16'h0004, 16'h0003, 16'h0002, 16'h0077});

`ifdef SEG_DUMP_EN
        begin
            logic [15:0] exp_w[4];
            logic        pat[5];
            int          w;
            int          cyc;
            exp_w = '{16'h0000, 16'hFFFF, 16'h0002, 16'h0003};
            pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

            // dump with ready toggling
            @(negedge clk);
            sif.st_dump_start = 1'b1;
            @(negedge clk);
            sif.st_dump_start = 1'b0;
            w = 0; cyc = 0;
            while (w < 4 && cyc < 12) begin
                if (cyc != 0) @(negedge clk);
                sif.st_dump_ready = pat[cyc % 5];
                #1;
                chk("dump_valid", 32'(sif.st_dump_valid), 32'd1);
                chk("dump_data", 32'(sif.st_dump_data), 32'(exp_w[w]));
                if (sif.st_dump_ready) w++;
                cyc++;
            end
            chk("dump_words", 32'(w), 32'd4);
            @(negedge clk);
            sif.st_dump_ready = 1'b0;
            #1;
            chk("dump_done", 32'(sif.done), 32'd1);
            chk("dump_idle", 32'(sif.busy), 32'd0);
            chk("dump_valid_off", 32'(sif.st_dump_valid), 32'd0);

            // CPU write in the start cycle delays the first valid
            @(negedge clk);
            sif.st_dump_start = 1'b1;
            sif.cpu_req = 1'b1; sif.cpu_id = 2'd0; sif.cpu_data = 16'h0000;
            #1;
            chk("dump_cpu_ack", 32'(sif.cpu_ack), 32'd1);
            push(2'd0, 16'h0000);
            @(negedge clk);
            sif.st_dump_start = 1'b0;
            sif.cpu_req = 1'b0;
            sif.st_dump_ready = 1'b1;
            #1;
            chk("dump_stall", 32'(sif.st_dump_valid), 32'd0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("dump2_valid", 32'(sif.st_dump_valid), 32'd1);
                chk("dump2_data", 32'(sif.st_dump_data), 32'(exp_w[k]));
            end
            @(negedge clk);
            sif.st_dump_ready = 1'b0;
            chk("dump2_done", 32'(sif.done), 32'd1);
        end
`else
        // dump start is ignored when the feature is absent
        @(negedge clk);
        sif.st_dump_start = 1'b1;
        sif.st_dump_ready = 1'b1;
        @(negedge clk);
        sif.st_dump_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("nodump_busy", 32'(sif.busy), 32'd0);
            chk("nodump_valid", 32'(sif.st_dump_valid), 32'd0);
            chk("nodump_data", 32'(sif.st_dump_data), 32'd0);
            @(negedge clk);
        end
        sif.st_dump_ready = 1'b0;
`endif

        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
